// File: rtl/fv_stream_rx.sv
// Edge-PE receiver: filters the FV stream by PE tag and deserializes element pairs into a
// vector presented over valid/ready. Define FV_RX_DBUF_EN for ping-pong double buffering.
module fv_stream_rx #(
  parameter int NUM_EDGE_PE = 4,
  parameter int MY_PE_TAG   = 0,
  parameter int MAX_FV_NUM  = 16,
  parameter int ELEM_W      = 8,
  parameter int TAG_W       = $clog2(NUM_EDGE_PE),
  parameter int LEN_W       = $clog2(MAX_FV_NUM) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LEN_W-1:0]             num_fv,
  input  logic                         in_valid,
  input  logic                         in_sos,
  input  logic                         in_eos,
  input  logic [TAG_W-1:0]             in_pe_tag,
  input  logic [2*ELEM_W-1:0]          in_fv_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MAX_FV_NUM*ELEM_W-1:0] out_fv,
  output logic [LEN_W-1:0]             out_len,
  output logic                         busy,
  output logic                         err,
  output logic [1:0]                   dbg_state
);

  localparam int BEAT_W = 2 * ELEM_W;
  localparam int VEC_W  = MAX_FV_NUM * ELEM_W;
  localparam int NPAIR  = MAX_FV_NUM / 2;
`ifdef FV_RX_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  // Output handshake: out_valid stays high with out_fv/out_len stable until a cycle
  // with out_ready=1; that cycle is the transfer. The input stream has no backpressure.

  typedef enum logic {C_IDLE, C_COLLECT} cstate_t;

  cstate_t          r_state;
  logic [VEC_W-1:0] r_buf [2];
  logic [LEN_W-1:0] r_len [2];
  logic [1:0]       r_full;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [LEN_W-1:0] r_cnt;
  logic             r_err;

  logic             w_acc;
  logic             w_xfer;
  logic             w_wr_free;
  logic             w_pair_ok;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             w_short_start;
  logic             w_short_coll;
  logic [LEN_W-1:0] w_len;
  logic [VEC_W-1:0] w_out_fv;

  assign w_acc     = in_valid && (in_pe_tag == TAG_W'(MY_PE_TAG));
  assign w_xfer    = r_full[r_rd_sel] && out_ready;
  // Single buffer: a same-cycle transfer does not free it, so a new sos there is overflow.
  assign w_wr_free = !r_full[r_wr_sel] || (DBUF && w_xfer && (r_rd_sel == r_wr_sel));
  assign w_pair_ok = (r_cnt < LEN_W'(NPAIR));
  assign w_cnt_nxt = w_pair_ok ? r_cnt + LEN_W'(1) : r_cnt;
  assign w_short_start = ({1'b0, num_fv} > (LEN_W+1)'(2));
  assign w_short_coll  = ({w_cnt_nxt, 1'b0} < {1'b0, r_len[r_wr_sel]});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= C_IDLE;
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        r_buf[b] <= '0;
        r_len[b] <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= DBUF ? ~r_rd_sel : 1'b0;
      end
      if (w_acc) begin
        if (in_sos && ((r_state == C_COLLECT) || w_wr_free)) begin
          // A restart mid-collection discards the partial vector.
          if (r_state == C_COLLECT) r_err <= 1'b1;
          r_buf[r_wr_sel] <= VEC_W'(in_fv_data);
          r_len[r_wr_sel] <= num_fv;
          r_cnt           <= LEN_W'(1);
          if (in_eos) begin
            r_full[r_wr_sel] <= 1'b1;
            r_wr_sel         <= DBUF ? ~r_wr_sel : 1'b0;
            r_state          <= C_IDLE;
            if (w_short_start) r_err <= 1'b1;
          end else begin
            r_state <= C_COLLECT;
          end
        end else if (!in_sos && (r_state == C_COLLECT)) begin
          if (w_pair_ok) r_buf[r_wr_sel][int'(r_cnt)*BEAT_W +: BEAT_W] <= in_fv_data;
          else           r_err <= 1'b1;
          r_cnt <= w_cnt_nxt;
          if (in_eos) begin
            r_full[r_wr_sel] <= 1'b1;
            r_wr_sel         <= DBUF ? ~r_wr_sel : 1'b0;
            r_state          <= C_IDLE;
            if (w_short_coll) r_err <= 1'b1;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign w_len = r_len[r_rd_sel];

  // Elements past the latched length read as zero whatever the stream carried.
  always_comb begin
    w_out_fv = '0;
    for (int i = 0; i < MAX_FV_NUM; i++) begin
      if (LEN_W'(i) < w_len) w_out_fv[i*ELEM_W +: ELEM_W] = r_buf[r_rd_sel][i*ELEM_W +: ELEM_W];
    end
  end

  assign out_valid = r_full[r_rd_sel];
  assign out_fv    = w_out_fv;
  assign out_len   = w_len;
  assign busy      = (r_state == C_COLLECT) || (|r_full);
  assign err       = r_err;
  assign dbg_state = {out_valid, r_state == C_COLLECT};

endmodule

// File: tb/tb_fv_stream_rx.sv
// Directed bench for fv_stream_rx (default parameters); expectations adapt when
// FV_RX_DBUF_EN is defined.
module tb_fv_stream_rx;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   num_fv;
  logic         in_valid;
  logic         in_sos;
  logic         in_eos;
  logic [1:0]   in_pe_tag;
  logic [15:0]  in_fv_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_fv;
  logic [4:0]   out_len;
  logic         busy;
  logic         err;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  fv_stream_rx dut (
    .clk        (clk),
    .reset      (reset),
    .num_fv     (num_fv),
    .in_valid   (in_valid),
    .in_sos     (in_sos),
    .in_eos     (in_eos),
    .in_pe_tag  (in_pe_tag),
    .in_fv_data (in_fv_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fv     (out_fv),
    .out_len    (out_len),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // driver tasks: inputs change on the falling edge, checks follow a falling edge
  task automatic send(input logic sos, input logic eos, input logic [1:0] tag,
                      input logic [15:0] d);
    @(negedge clk);
    in_valid   = 1'b1;
    in_sos     = sos;
    in_eos     = eos;
    in_pe_tag  = tag;
    in_fv_data = d;
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
    in_sos   = 1'b0;
    in_eos   = 1'b0;
  endtask

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; num_fv = '0; in_valid = 1'b0; in_sos = 1'b0; in_eos = 1'b0;
    in_pe_tag = '0; in_fv_data = '0; out_ready = 1'b1;
    do_reset();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_fv", out_fv, 0);
    check_eq("rst_len", out_len, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_dbg", dbg_state, 0);

    // single-beat vector
    num_fv = 5'd2;
    send(1, 1, 0, 16'hB2A1);
    gap();
    check_eq("sb_valid", out_valid, 1);
    check_eq("sb_fv", out_fv, 128'hB2A1);
    check_eq("sb_len", out_len, 2);
    check_eq("sb_busy", busy, 1);
    gap();
    check_eq("sb_idle_valid", out_valid, 0);
    check_eq("sb_idle_busy", busy, 0);

    // odd length: upper byte of the tail pair is masked
    num_fv = 5'd5;
    send(1, 0, 0, 16'h0201);
    send(0, 0, 0, 16'h0403);
    check_eq("odd_busy", busy, 1);
    check_eq("odd_valid_early", out_valid, 0);
    send(0, 1, 0, 16'hFF05);
    gap();
    check_eq("odd_fv", out_fv, 128'h0504030201);
    check_eq("odd_len", out_len, 5);
    check_eq("odd_err", err, 0);
    gap();

    // tag filter, other-tag beats including an sos are ignored
    out_ready = 1'b0;
    num_fv = 5'd4;
    send(1, 0, 0, 16'h1111);
    send(0, 0, 1, 16'hDEAD);
    send(1, 0, 1, 16'hDEAD);
    send(0, 1, 0, 16'h2222);
    send(1, 1, 1, 16'hDEAD);
    check_eq("tag_valid", out_valid, 1);
    check_eq("tag_fv", out_fv, 128'h22221111);
    gap();
    check_eq("tag_hold_fv", out_fv, 128'h22221111);
    check_eq("tag_err", err, 0);
    out_ready = 1'b1;
    gap();
    check_eq("tag_done", out_valid, 0);

    // non-sos beat in IDLE
    send(0, 0, 0, 16'h1234);
    gap();
    check_eq("idle_nosos_err", err, 1);
    check_eq("idle_nosos_valid", out_valid, 0);
    do_reset();
    check_eq("err_cleared", err, 0);

    // second sos during collection restarts the vector
    num_fv = 5'd4;
    send(1, 0, 0, 16'h5555);
    send(1, 0, 0, 16'h7777);
    send(0, 1, 0, 16'h8888);
    gap();
    check_eq("restart_fv", out_fv, 128'h88887777);
    check_eq("restart_len", out_len, 4);
    check_eq("restart_err", err, 1);
    gap();

    // new sos while holding with out_ready low
    do_reset();
    out_ready = 1'b0;
    num_fv = 5'd2;
    send(1, 1, 0, 16'hAAAA);
    send(1, 1, 0, 16'hBBBB);
    gap();
    check_eq("ovf_valid", out_valid, 1);
    check_eq("ovf_fv", out_fv, 128'hAAAA);
`ifdef FV_RX_DBUF_EN
    check_eq("ovf_err", err, 0);
    out_ready = 1'b1;
    gap();
    check_eq("ovf_second_valid", out_valid, 1);
    check_eq("ovf_second_fv", out_fv, 128'hBBBB);
    gap();
    check_eq("ovf_drained", out_valid, 0);
`else
    check_eq("ovf_err", err, 1);
    out_ready = 1'b1;
    gap();
    check_eq("ovf_drained", out_valid, 0);
`endif

    // sos in the same cycle as a transfer
    do_reset();
    out_ready = 1'b1;
    send(1, 1, 0, 16'h1111);
    send(1, 1, 0, 16'h2222);
    gap();
`ifdef FV_RX_DBUF_EN
    check_eq("same_valid", out_valid, 1);
    check_eq("same_fv", out_fv, 128'h2222);
    check_eq("same_err", err, 0);
`else
    check_eq("same_valid", out_valid, 0);
    check_eq("same_err", err, 1);
`endif
    gap();

    // eos before the announced length
    do_reset();
    out_ready = 1'b0;
    num_fv = 5'd6;
    send(1, 0, 0, 16'h0201);
    send(0, 1, 0, 16'h0403);
    gap();
    check_eq("short_valid", out_valid, 1);
    check_eq("short_fv", out_fv, 128'h04030201);
    check_eq("short_len", out_len, 6);
    check_eq("short_err", err, 1);
    out_ready = 1'b1;
    gap();

    // reset mid-collection, then a clean 4-beat vector
    do_reset();
    num_fv = 5'd8;
    send(1, 0, 0, 16'h0101);
    send(0, 0, 0, 16'h0202);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_fv", out_fv, 0);
    check_eq("midrst_len", out_len, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_err", err, 0);
    reset = 1'b0;
    out_ready = 1'b0;
    send(1, 0, 0, 16'h2211);
    send(0, 0, 0, 16'h4433);
    send(0, 0, 0, 16'h6655);
    send(0, 1, 0, 16'h8877);
    gap();
    check_eq("post_fv", out_fv, 128'h8877665544332211);
    check_eq("post_len", out_len, 8);
    check_eq("post_err", err, 0);
    out_ready = 1'b1;
    gap();
    check_eq("post_done", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
